// File: rtl/lcg_stream_if.sv
// Seed-load and result handshake bundle for lcg_stream.
// The slave modport is the generator side; the master modport is the consumer/controller side.
interface lcg_stream_if #(
    parameter int WIDTH = 32
);
    logic             seed_valid;
    logic [WIDTH-1:0] seed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             busy;

    modport master (
        output seed_valid, seed, out_ready,
        input  out_valid, out_value, busy
    );

    modport slave (
        input  seed_valid, seed, out_ready,
        output out_valid, out_value, busy
    );
endinterface

// File: rtl/lcg_stream.sv
// Free-running linear congruential generator: X <= (a*X + c) mod m, reduced bit-serially.
// Optional macro LCG_COUNT_EN adds a 32-bit accept_count output.
//
// state | meaning
// MUL   | latch modulus, form P = a*X + c, arm the reduction counter
// RED   | restoring reduction of P, one bit of P per cycle, MSB first
// HOLD  | result valid, waiting for the consumer to accept it
module lcg_stream #(
    parameter int          WIDTH        = 32,
    parameter int unsigned DEFAULT_SEED = 96
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] MODULUS,
    input  logic [WIDTH-1:0] MULTIPLIER,
    input  logic [WIDTH-1:0] INCREMENT,
    lcg_stream_if.slave      io
`ifdef LCG_COUNT_EN
    ,
    output logic [31:0]      accept_count
`endif
);

    localparam int PW = 2 * WIDTH + 1;
    localparam int MW = WIDTH + 2;
    localparam int CW = $clog2(PW);

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        RED  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic [MW-1:0]    trial;
    logic [MW-1:0]    m_ext;
    logic [WIDTH:0]   red_r;

    assign accept = out_valid_q & io.out_ready;

    // m == 0 stands for 2^WIDTH, so the reduction simply drops the top bit
    always_comb begin
        trial = {r_q, p_q[PW-1]};
        m_ext = (m_q == '0) ? (MW'(1) << WIDTH) : MW'(m_q);
        red_r = (trial >= m_ext) ? (WIDTH+1)'(trial - m_ext) : trial[WIDTH:0];
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        m_d         = m_q;
        p_d         = p_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;

        unique case (state_q)
            MUL: begin
                m_d     = MODULUS;
                p_d     = PW'(MULTIPLIER) * PW'(x_q) + PW'(INCREMENT);
                r_d     = '0;
                cnt_d   = CW'(PW - 1);
                state_d = RED;
            end
            RED: begin
                r_d = red_r;
                p_d = p_q << 1;
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    out_value_d = red_r[WIDTH-1:0];
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (accept) begin
                    x_d         = out_value_q;
                    out_valid_d = 1'b0;
                    state_d     = MUL;
                end
            end
            default: state_d = MUL;
        endcase

        // A seed load overrides everything, including a same-cycle accept
        if (io.seed_valid) begin
            x_d         = io.seed;
            out_valid_d = 1'b0;
            state_d     = MUL;
        end

        busy_d = (state_d != HOLD);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= MUL;
            x_q         <= WIDTH'(DEFAULT_SEED);
            m_q         <= '0;
            p_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            m_q         <= m_d;
            p_q         <= p_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            busy_q      <= busy_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_value = out_value_q;
    assign io.busy      = busy_q;

`ifdef LCG_COUNT_EN
    logic [31:0] accept_count_q, accept_count_d;

    always_comb begin
        accept_count_d = accept_count_q + 32'(accept);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            accept_count_q <= '0;
        end else begin
            accept_count_q <= accept_count_d;
        end
    end

    assign accept_count = accept_count_q;
`endif

endmodule

// File: tb/tb_lcg_stream.sv
// Directed self-checking bench for lcg_stream (WIDTH=32), with hand-computed LCG results.
// Builds with or without LCG_COUNT_EN.
module tb_lcg_stream;

    logic        CLK;
    logic        RST_N;
    logic [31:0] MODULUS;
    logic [31:0] MULTIPLIER;
    logic [31:0] INCREMENT;
`ifdef LCG_COUNT_EN
    logic [31:0] accept_count;
    logic [31:0] cnt_before;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    int bad;

    lcg_stream_if #(.WIDTH(32)) bus ();

    lcg_stream #(
        .WIDTH       (32),
        .DEFAULT_SEED(96)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .MODULUS     (MODULUS),
        .MULTIPLIER  (MULTIPLIER),
        .INCREMENT   (INCREMENT),
        .io          (bus.slave)
`ifdef LCG_COUNT_EN
        ,
        .accept_count(accept_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input int max, output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < max) begin
            tick();
            cycles++;
        end
    endtask

    task automatic accept_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic load_seed(input logic [31:0] s);
        bus.seed_valid = 1'b1;
        bus.seed       = s;
        tick();
        bus.seed_valid = 1'b0;
    endtask

    initial begin
        RST_N          = 1'b0;
        MODULUS        = 32'd993441;
        MULTIPLIER     = 32'd4001;
        INCREMENT      = 32'd60211;
        bus.seed_valid = 1'b0;
        bus.seed       = '0;
        bus.out_ready  = 1'b0;

        // reset values
        repeat (3) tick();
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_value", bus.out_value, 0);
        check_eq("rst_busy", bus.busy, 0);
`ifdef LCG_COUNT_EN
        check_eq("rst_count", accept_count, 0);
`endif

        // first result: 4001*96 + 60211 = 444307
        RST_N = 1'b1;
        tick();
        check_eq("busy_in_red", bus.busy, 1);
        wait_valid(300, n);
        check_eq("lat_first", n + 1, 66);
        check_eq("val_first", bus.out_value, 444307);
        check_eq("busy_in_hold", bus.busy, 0);

        // backpressure: result must hold for 200 cycles
        bad = 0;
        repeat (200) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_value !== 32'd444307) bad++;
        end
        check_eq("hold_stable", bad, 0);

        accept_one();
        check_eq("drop_after_accept", bus.out_valid, 0);
`ifdef LCG_COUNT_EN
        check_eq("count_one", accept_count, 1);
`endif
        wait_valid(300, n);
        check_eq("lat_second", n, 66);
        check_eq("val_second", bus.out_value, 466569);

        // seed pulsed partway through RED discards the partial result
        accept_one();
        tick();
        repeat (29) tick();
        check_eq("busy_mid_red", bus.busy, 1);
        load_seed(32'd96);
        check_eq("seed_no_valid", bus.out_valid, 0);
        wait_valid(300, n);
        check_eq("lat_after_seed", n, 66);
        check_eq("val_after_seed", bus.out_value, 444307);

        // config changed during RED only applies at the next MUL
        accept_one();
        tick();
        MODULUS    = 32'd7;
        MULTIPLIER = 32'd3;
        INCREMENT  = 32'd4;
        wait_valid(300, n);
        check_eq("lat_cfg_change", n, 65);
        check_eq("val_cfg_ignored", bus.out_value, 466569);
        accept_one();
        wait_valid(300, n);
        check_eq("val_cfg_applied", bus.out_value, 5);

        // seed above modulus still fully reduced: 2000000 mod 993441 = 13118
        MODULUS    = 32'd993441;
        MULTIPLIER = 32'd1;
        INCREMENT  = 32'd0;
`ifdef LCG_COUNT_EN
        cnt_before = accept_count;
`endif
        load_seed(32'd2000000);
        wait_valid(300, n);
        check_eq("lat_big_seed", n, 66);
        check_eq("val_big_seed", bus.out_value, 13118);
`ifdef LCG_COUNT_EN
        check_eq("count_seed_only", accept_count, cnt_before);
`endif

        // seed and accept in the same cycle: seed wins, accept still counted
        MULTIPLIER = 32'd4001;
        INCREMENT  = 32'd60211;
`ifdef LCG_COUNT_EN
        cnt_before = accept_count;
`endif
        bus.out_ready  = 1'b1;
        bus.seed_valid = 1'b1;
        bus.seed       = 32'd96;
        tick();
        bus.out_ready  = 1'b0;
        bus.seed_valid = 1'b0;
`ifdef LCG_COUNT_EN
        check_eq("count_seed_accept", accept_count, cnt_before + 32'd1);
`endif
        wait_valid(300, n);
        check_eq("val_seed_wins", bus.out_value, 444307);

        // modulus 0 means 2^32: 0xFFFFFFFF + 1 wraps to 0, then 1, 2
        MODULUS    = 32'd0;
        MULTIPLIER = 32'd1;
        INCREMENT  = 32'd1;
        load_seed(32'hFFFF_FFFF);
        wait_valid(300, n);
        check_eq("lat_wrap", n, 66);
        check_eq("val_wrap0", bus.out_value, 0);
        accept_one();
        wait_valid(300, n);
        check_eq("val_wrap1", bus.out_value, 1);
        accept_one();
        wait_valid(300, n);
        check_eq("val_wrap2", bus.out_value, 2);

        // short async reset mid-RED, between clock edges
        MODULUS    = 32'd993441;
        MULTIPLIER = 32'd4001;
        INCREMENT  = 32'd60211;
        accept_one();
        tick();
        repeat (10) tick();
        check_eq("busy_before_rst", bus.busy, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("async_busy", bus.busy, 0);
        check_eq("async_out_valid", bus.out_valid, 0);
        check_eq("async_out_value", bus.out_value, 0);
`ifdef LCG_COUNT_EN
        check_eq("async_count", accept_count, 0);
`endif
        #2;
        RST_N = 1'b1;
        wait_valid(300, n);
        check_eq("lat_after_rst", n, 66);
        check_eq("val_after_rst", bus.out_value, 444307);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcg_stream.md
LCG_STREAM -- requirements
Module: lcg_stream

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the state, modulus, multiplier, increment and output width in bits (legal values 8..32).
REQ-002 The module SHALL have parameter DEFAULT_SEED, default 96, giving the state value loaded at reset.
REQ-003 CLK  input  1  single clock; all state SHALL change only on its rising edge, except for reset.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 MODULUS  input  WIDTH  m; a value of 0 means modulus 2^WIDTH.
REQ-006 MULTIPLIER  input  WIDTH  a.
REQ-007 INCREMENT  input  WIDTH  c.
REQ-008 seed_valid  input  1  one-cycle request to load seed into the state.
REQ-009 seed  input  WIDTH  new state value X.
REQ-010 out_valid  output  1  out_value holds a finished result.
REQ-011 out_ready  input  1  consumer accepts out_value when out_valid and out_ready are both high.
REQ-012 out_value  output  WIDTH  next X = (a*X + c) mod m.
REQ-013 busy  output  1  a computation is in progress (states MUL or RED).

Function
REQ-014 States: MUL, RED, HOLD; there SHALL be no idle state, so the generator is free-running under backpressure.
REQ-015 MUL, 1 cycle: latch MODULUS, MULTIPLIER and INCREMENT; form P = a*X + c, 2*WIDTH+1 bits wide with no truncation; go to RED.
REQ-016 RED, exactly 2*WIDTH+1 cycles: restoring bit-serial reduction, MSB first; each cycle r = (r<<1)|bit, and if r >= m then r = r - m; the r register is WIDTH+1 bits wide.
REQ-017 When m = 0, RED SHALL still take 2*WIDTH+1 cycles, and the result SHALL be P[WIDTH-1:0].
REQ-018 Results SHALL be fully reduced (out_value < m when m != 0), even if seed >= m.
REQ-019 Latency: if MUL is in cycle S, out_valid SHALL rise in cycle S+2*WIDTH+2 (S+66 for WIDTH=32), and the state SHALL enter HOLD in that cycle.
REQ-020 HOLD: out_valid=1; out_value and X SHALL be held stable until accepted.
REQ-021 On acceptance: X <= out_value, out_valid SHALL drop in the next cycle, and MUL SHALL follow in the next cycle.
REQ-022 Config inputs that change during RED or HOLD SHALL NOT affect the current result; they SHALL take effect at the next MUL.
REQ-023 seed_valid in any state: X <= seed, the current computation or held result is discarded, out_valid <= 0, and the next state is MUL.
REQ-024 When seed_valid and an accept occur in the same cycle, seed SHALL win, and the accepted value counts as consumed.

Reset
REQ-025 While RST_N=0: X=DEFAULT_SEED, out_valid=0, out_value=0, busy=0, r=0, and state=MUL.
REQ-026 The first MUL SHALL occur in the first rising CLK edge after RST_N deasserts.
REQ-027 Reset asserted mid-computation SHALL discard all progress immediately, without waiting for a clock edge.

Configuration
REQ-028 Macro LCG_COUNT_EN, when defined, SHALL add output port accept_count (32 bits): it resets to 0, increments by 1 on each accept, wraps from 2^32-1 to 0, and is unaffected by seed_valid.
REQ-029 Without LCG_COUNT_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 WIDTH=32; m=993441, a=4001, c=60211; release reset; out_ready=1 -> out_valid in cycle 66 with out_value=444307; second result 466569, also 66 cycles after its MUL.
REQ-031 out_ready=0 for 200 cycles after the first result -> out_value stays 444307 with out_valid=1 throughout; raise out_ready -> next result 466569.
REQ-032 m=0, a=1, c=1; seed=32'hFFFFFFFF -> out_value=0 (wrap-around); then 1, 2.
REQ-033 seed_valid with seed=96 pulsed in cycle 30 of RED -> partial result discarded; exactly one result, 444307, appears 66 cycles after the seed cycle.
REQ-034 seed_valid and an accept in the same cycle -> new seed used; with LCG_COUNT_EN, accept_count increments by 1.
REQ-035 RST_N pulsed low for a fraction of a cycle mid-RED -> out_valid=0 and busy=0 asynchronously; sequence restarts at 444307.
